hazard_ctrl: RTL
================

HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameter AW, 5, register address width.
REQ-002 Parameter FWD_EN, 1, 1 = forwarding path exists, stall only on load-use; 0 = stall on any RAW against ID/EX or EX/MEM.
REQ-003 Parameter BR_MODE, 1, 0 = freeze fetch until branch resolves; 1 = predict-not-taken with flush on taken.
REQ-004 Parameter CNT_W, 16, stall counter width.
REQ-005 clk  in  1  single clock, rising edge.
REQ-006 rst_n  in  1  asynchronous, active-low reset.
REQ-007 rs1_addr_id  in  AW  rs1 of instruction in ID.
REQ-008 rs2_addr_id  in  AW  rs2 of instruction in ID.
REQ-009 rs1_used  in  1  ID instruction reads rs1.
REQ-010 rs2_used  in  1  ID instruction reads rs2.
REQ-011 regwrite_idex  in  1  EX-stage instruction writes rd.
REQ-012 memread_idex  in  1  EX-stage instruction is a load.
REQ-013 rd_idex  in  AW  EX-stage destination.
REQ-014 regwrite_exmem  in  1  MEM-stage instruction writes rd.
REQ-015 rd_exmem  in  AW  MEM-stage destination.
REQ-016 branch_id  in  1  ID instruction is branch/jump.
REQ-017 br_resolve_ex  in  1  branch/jump resolves in EX this cycle.
REQ-018 br_taken_ex  in  1  resolved branch redirects PC; qualified by br_resolve_ex.
REQ-019 mc_start_ex  in  1  multicycle (mul/div) op enters EX this cycle.
REQ-020 mc_done  in  1  multicycle unit result valid this cycle.
REQ-021 en_if, en_ifid, en_idex  out  1 each  PC, IF/ID, ID/EX load enables.
REQ-022 nop_ifid, nop_idex, nop_exmem  out  1 each  insert bubble into that pipeline register.
REQ-023 stall_cnt  out  CNT_W  saturating count of cycles with en_if=0 or any flush.

Function
REQ-024 Raw hazard hit = regwrite && rd!=0 && ((rs1_used && rs1==rd) || (rs2_used && rs2==rd)).
REQ-025 FWD_EN=1: data_stall = hit vs ID/EX AND memread_idex; FWD_EN=0: data_stall = hit vs ID/EX OR hit vs EX/MEM; register file is write-before-read, MEM/WB never stalls.
REQ-026 FSM states RUN, MC, BWAIT; outputs combinational from state and inputs.
REQ-027 RUN, data_stall: en_if=en_ifid=0, en_idex=1, nop_idex=1; one cycle per evaluation, repeats while hazard persists.
REQ-028 RUN, mc_start_ex && !mc_done -> MC; same cycle en_if=en_ifid=en_idex=0, nop_exmem=1.
REQ-029 MC: en_if=en_ifid=en_idex=0, nop_exmem=1 until mc_done; mc_done cycle all enables 1, nop_exmem=0, -> RUN next edge.
REQ-030 BR_MODE=1, br_resolve_ex && br_taken_ex: nop_ifid=nop_idex=1, en_if=1 (PC loads target); overrides data_stall.
REQ-031 BR_MODE=0, RUN with branch_id and no data_stall: en_if=0, nop_ifid=1, -> BWAIT; BWAIT holds en_if=0, nop_ifid=1 until br_resolve_ex, that cycle en_if=1, nop_ifid=0, -> RUN.
REQ-032 Priority on simultaneous events: MC entry > taken redirect > data_stall > branch_id; mc_start_ex with mc_done same cycle = no stall, stay RUN.
REQ-033 br_resolve_ex in MC is ignored (branch cannot occupy EX with mc op).
REQ-034 stall_cnt increments by 1 per qualifying cycle, holds at 2^CNT_W-1.

Reset
REQ-035 rst_n low: state=RUN, stall_cnt=0 immediately; enables=1 and nops=0 while rst_n low, including reset asserted mid-MC or mid-BWAIT.

Structure
REQ-036 State encoding (2-bit enum) and AW default in shared package hazard_pkg; single module, hazard detect comparator may be sub-module raw_detect.

Verification
REQ-037 FWD_EN=1, load x5 in EX, ID add uses x5 -> one cycle en_if=0, nop_idex=1; same with non-load -> no stall.
REQ-038 FWD_EN=0, rd_exmem=x7 regwrite, ID uses x7 -> stall; rd=x0 -> no stall.
REQ-039 mc_start_ex, mc_done 4 cycles later -> 4 cycles enables 0, nop_exmem=1, stall_cnt=4.
REQ-040 BR_MODE=1 taken branch in EX -> nop_ifid=nop_idex=1, en_if=1 one cycle; not taken -> no flush.
REQ-041 BR_MODE=0 branch_id, resolve 2 cycles later -> en_if=0 for 2 cycles, then 1; rst_n pulse mid-BWAIT -> RUN, stall_cnt=0.

Source files
------------

// File: rtl/hazard_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_pkg
//  Description : Shared definitions for the pipeline hazard controller:
//                default register-address width and the 2-bit FSM state enum.
//  Revision    : 1.0  initial release
// ============================================================================
package hazard_pkg;

    localparam int AW_DEFAULT = 5;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,   // normal flow
        ST_MC    = 2'd1,   // waiting on multicycle unit
        ST_BWAIT = 2'd2    // fetch frozen until branch resolves
    } state_t;

endpackage : hazard_pkg
`default_nettype wire

// File: rtl/raw_detect.sv
`default_nettype none
// ============================================================================
//  Module      : raw_detect
//  Description : Read-after-write comparator between the ID-stage source
//                registers and one downstream destination register.
//  Ports       : rs1_addr/rs2_addr  ID source addresses
//                rs1_used/rs2_used  source actually read
//                regwrite/rd_addr   downstream instruction writes rd_addr
//                hit                RAW dependency exists
//  Revision    : 1.0  initial release
// ============================================================================
module raw_detect
    import hazard_pkg::*;
#(
    parameter int AW = AW_DEFAULT
) (
    input  logic [AW-1:0] rs1_addr,
    input  logic [AW-1:0] rs2_addr,
    input  logic          rs1_used,
    input  logic          rs2_used,
    input  logic          regwrite,
    input  logic [AW-1:0] rd_addr,
    output logic          hit
);

    // x0 is hard-wired zero, so a write to it never creates a dependency.
    always_comb begin
        hit = regwrite && (rd_addr != '0) &&
              ((rs1_used && (rs1_addr == rd_addr)) ||
               (rs2_used && (rs2_addr == rd_addr)));
    end

endmodule : raw_detect
`default_nettype wire

// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_ctrl
//  Description : Pipeline hazard controller. Detects load-use / RAW data
//                hazards, handles branch freeze or flush, and stalls the
//                front end while a multicycle op occupies EX.
//  Ports       : clk, rst_n                 clock, async active-low reset
//                rs*_addr_id, rs*_used      ID-stage source operands
//                regwrite/memread/rd_idex   EX-stage instruction
//                regwrite/rd_exmem          MEM-stage instruction
//                branch_id, br_resolve_ex,  branch in ID / resolution in EX
//                br_taken_ex
//                mc_start_ex, mc_done       multicycle unit handshake
//                en_if/en_ifid/en_idex      pipeline register load enables
//                nop_ifid/nop_idex/nop_exmem bubble inserts
//                stall_cnt                  saturating stall/flush counter
//  Revision    : 1.0  initial release
// ============================================================================
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int AW      = AW_DEFAULT,
    parameter bit FWD_EN  = 1'b1,
    parameter bit BR_MODE = 1'b1,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [AW-1:0]    rs1_addr_id,
    input  logic [AW-1:0]    rs2_addr_id,
    input  logic             rs1_used,
    input  logic             rs2_used,
    input  logic             regwrite_idex,
    input  logic             memread_idex,
    input  logic [AW-1:0]    rd_idex,
    input  logic             regwrite_exmem,
    input  logic [AW-1:0]    rd_exmem,
    input  logic             branch_id,
    input  logic             br_resolve_ex,
    input  logic             br_taken_ex,
    input  logic             mc_start_ex,
    input  logic             mc_done,
    output logic             en_if,
    output logic             en_ifid,
    output logic             en_idex,
    output logic             nop_ifid,
    output logic             nop_idex,
    output logic             nop_exmem,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam logic [CNT_W-1:0] c_CNT_ONE = CNT_W'(1);

    state_t           r_state;
    state_t           w_nxt;
    logic [CNT_W-1:0] r_cnt;

    logic w_hit_idex, w_hit_exmem, w_data_stall, w_taken;
    logic w_en_if, w_en_ifid, w_en_idex;
    logic w_nop_ifid, w_nop_idex, w_nop_exmem;
    logic w_count;

    raw_detect #(.AW(AW)) u_raw_idex (
        .rs1_addr (rs1_addr_id),
        .rs2_addr (rs2_addr_id),
        .rs1_used (rs1_used),
        .rs2_used (rs2_used),
        .regwrite (regwrite_idex),
        .rd_addr  (rd_idex),
        .hit      (w_hit_idex)
    );

    raw_detect #(.AW(AW)) u_raw_exmem (
        .rs1_addr (rs1_addr_id),
        .rs2_addr (rs2_addr_id),
        .rs1_used (rs1_used),
        .rs2_used (rs2_used),
        .regwrite (regwrite_exmem),
        .rd_addr  (rd_exmem),
        .hit      (w_hit_exmem)
    );

    // With forwarding only a load in EX cannot be bypassed in time; without
    // it any in-flight writer in EX or MEM must drain. WB is covered by the
    // write-before-read register file.
    assign w_data_stall = FWD_EN ? (w_hit_idex && memread_idex)
                                 : (w_hit_idex || w_hit_exmem);

    assign w_taken = BR_MODE && br_resolve_ex && br_taken_ex;

    always_comb begin
        w_nxt       = r_state;
        w_en_if     = 1'b1;
        w_en_ifid   = 1'b1;
        w_en_idex   = 1'b1;
        w_nop_ifid  = 1'b0;
        w_nop_idex  = 1'b0;
        w_nop_exmem = 1'b0;
        case (r_state)
            ST_RUN: begin
                // A multicycle op that completes in its first cycle needs no
                // stall, so lower-priority events are still evaluated.
                if (mc_start_ex && !mc_done) begin
                    w_en_if     = 1'b0;
                    w_en_ifid   = 1'b0;
                    w_en_idex   = 1'b0;
                    w_nop_exmem = 1'b1;
                    w_nxt       = ST_MC;
                end else if (w_taken) begin
                    // PC loads the target; the two wrong-path slots are killed.
                    w_nop_ifid  = 1'b1;
                    w_nop_idex  = 1'b1;
                end else if (w_data_stall) begin
                    w_en_if     = 1'b0;
                    w_en_ifid   = 1'b0;
                    w_nop_idex  = 1'b1;
                end else if (!BR_MODE && branch_id) begin
                    w_en_if     = 1'b0;
                    w_nop_ifid  = 1'b1;
                    w_nxt       = ST_BWAIT;
                end
            end
            ST_MC: begin
                // Branch resolution is impossible here: EX holds the mc op.
                if (mc_done) begin
                    w_nxt       = ST_RUN;
                end else begin
                    w_en_if     = 1'b0;
                    w_en_ifid   = 1'b0;
                    w_en_idex   = 1'b0;
                    w_nop_exmem = 1'b1;
                end
            end
            ST_BWAIT: begin
                if (br_resolve_ex) begin
                    w_nxt       = ST_RUN;
                end else begin
                    w_en_if     = 1'b0;
                    w_nop_ifid  = 1'b1;
                end
            end
            default: w_nxt = ST_RUN;
        endcase
    end

    // Outputs are forced to pass-through while reset is held, whatever state
    // the FSM was in when reset arrived.
    assign en_if     = w_en_if     || !rst_n;
    assign en_ifid   = w_en_ifid   || !rst_n;
    assign en_idex   = w_en_idex   || !rst_n;
    assign nop_ifid  = w_nop_ifid  && rst_n;
    assign nop_idex  = w_nop_idex  && rst_n;
    assign nop_exmem = w_nop_exmem && rst_n;

    assign w_count   = !w_en_if || w_nop_ifid || w_nop_idex;
    assign stall_cnt = r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_RUN;
            r_cnt   <= '0;
        end else begin
            r_state <= w_nxt;
            if (w_count && (r_cnt != '1)) begin
                r_cnt <= r_cnt + c_CNT_ONE;
            end
        end
    end

endmodule : hazard_ctrl
`default_nettype wire
